dlx_step_controller: RTL
========================

# dlx_step_controller

Host-driven execution controller for the DLX core under test, sitting directly upstream of `monitor_new`. It decodes host write commands from the slave bus and produces the DLX/logic-analyzer control strobes `step_en`, `in_init` and `stop_n`. It also produces the 32-bit step counter that `monitor_new` returns to the host on slave mux input 3. It supports single-step, bounded run, free run, stop and init sequencing, and latches DLX halt.

## Interface
- `CMD_ADDR`, 10'h200, slave address of the command register.
- `INIT_CYCLES`, 4, number of cycles `in_init` is held high per INIT command (minimum 1).
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  reset, synchronous, active-low.
- `CARDSEL`  in  1  slave bus select, shared with `monitor_new`.
- `WR_N`  in  1  slave bus write strobe, active-low.
- `AI`  in  10  slave bus address.
- `SDI`  in  32  host write data. [2:0] is the opcode; [31:16] is the run length.
- `halt`  in  1  DLX has executed HALT, active-high, level.
- `step_en`  out  1  one DLX/analyzer step per high cycle; feeds `monitor_new.step_en`.
- `in_init`  out  1  init sequence active; feeds `monitor_new.in_init`.
- `stop_n`  out  1  low while halted; feeds `monitor_new.stop_n`.
- `step_counter`  out  32  total steps issued since the last INIT or reset; feeds `monitor_new.mux_in_3`.
- `busy`  out  1  high in INIT, STEP and RUN.

## Operation
- Write detect: `wr = CARDSEL & ~WR_N & (AI == CMD_ADDR)`.
  - A command is accepted only on the rising edge of `wr` (previous-cycle `wr` registered).
  - A held write therefore issues exactly one command.
- Opcodes:
  - 3'b001 INIT
  - 3'b010 STEP
  - 3'b011 RUN (`SDI[31:16]` = step count; 0 = free run)
  - 3'b100 STOP
  - All others are ignored.
- States: IDLE, INIT, STEP, RUN, HALTED.
- IDLE:
  - INIT → INIT.
  - STEP → STEP.
  - RUN → RUN, loading `remaining = SDI[31:16]`.
  - STOP is ignored.
- INIT:
  - `in_init` = 1 for exactly `INIT_CYCLES` cycles.
  - `step_counter` is cleared on entry.
  - Then → IDLE.
- STEP: `step_en` = 1 for exactly one cycle. Then → HALTED if `halt` was sampled high that cycle, else → IDLE.
- RUN:
  - `step_en` = 1 every cycle.
  - For bounded runs, `remaining` decrements per step; after the last step → IDLE.
  - STOP → IDLE.
  - `halt` high → HALTED.
- HALTED:
  - `stop_n` = 0.
  - Only INIT leaves this state; STEP, RUN and STOP are ignored.
- INIT is accepted in every state and aborts STEP and RUN. STEP and RUN commands are ignored while `busy`.
- `step_counter` increments by 1 in every cycle where `step_en` = 1, and wraps from 32'hFFFF_FFFF to 0.

## Timing
- All outputs are registered.
- Reset values: `step_en` = 0, `in_init` = 0, `stop_n` = 1, `step_counter` = 0, `busy` = 0, state IDLE. Reset mid-operation returns to these values the next cycle.
- Latency:
  - Command edge sampled at cycle N → first `step_en` or `in_init` high at N+1.
  - `busy` also rises at N+1.
- Bounded RUN of K steps: `step_en` is high for exactly K consecutive cycles, then `busy` falls in the following cycle.
- STOP accepted at cycle M during RUN: `step_en` is 0 from M+1. Steps issued through M are counted.
- `halt` sampled high in a cycle where `step_en` = 1:
  - That step is counted.
  - `step_en` = 0 and `stop_n` = 0 from the next cycle.
- `halt` sampled high in IDLE has no effect until the next STEP or RUN. That STEP or RUN issues one step, then goes → HALTED.
- RUN reaching `remaining` = 0 in the same cycle as `halt`: HALTED wins.
- INIT from HALTED: `stop_n` returns to 1 on the first `in_init` cycle.

## Structure
- Shared package `dlx_ctrl_pkg` holds:
  - the opcode constants (OP_INIT, OP_STEP, OP_RUN, OP_STOP);
  - the state enum;
  - the default `CMD_ADDR`.
- One sub-module, `step_cmd_decode`: address match, write edge detect, and the opcode/run-length outputs with a one-cycle `cmd_valid`.
- The FSM, the counters and the output registers live in the top.

## Test plan
- Reset release, no writes → `step_en` = 0, `in_init` = 0, `stop_n` = 1, `step_counter` = 0 for 20 cycles.
- Write STEP with CARDSEL/WR_N held 5 cycles → exactly one `step_en` pulse, 1 cycle after the edge; `step_counter` = 1.
- INIT with `INIT_CYCLES` = 4, then RUN with `SDI` = 32'h0005_0003 → `in_init` high for 4 cycles; then `step_en` high for 5 consecutive cycles; `step_counter` = 5; `busy` falls 1 cycle after the last step.
- Free RUN (`SDI` = 32'h0000_0003), STOP written after 10 steps → `step_en` low on the next cycle; `step_counter` = 10 plus any steps in the decode cycle, checked cycle-exactly.
- Free RUN, `halt` asserted on the 7th step cycle → `step_counter` = 7, `stop_n` = 0; a subsequent STEP is ignored; INIT restores `stop_n` = 1 and clears the counter.
- `step_counter` forced to 32'hFFFF_FFFF, then STEP → counter = 0; assert `reset` low mid-RUN → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/dlx_ctrl_pkg.sv
// Shared opcodes, FSM states and bus address for the DLX step controller.
// Imported by the command decoder and the controller top.
package dlx_ctrl_pkg;

  localparam logic [9:0] CMD_ADDR_DEF = 10'h200;

  localparam logic [2:0] OP_INIT = 3'b001;
  localparam logic [2:0] OP_STEP = 3'b010;
  localparam logic [2:0] OP_RUN  = 3'b011;
  localparam logic [2:0] OP_STOP = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_STEP,
    S_RUN,
    S_HALTED
  } state_e;

endpackage

// File: rtl/step_cmd_decode.sv
// Command register address match and write-edge detect.
// cmd_valid pulses for one cycle on the rising edge of a matching write.
module step_cmd_decode
  import dlx_ctrl_pkg::*;
#(
  parameter logic [9:0] CMD_ADDR = CMD_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cardsel,
  input  logic        wr_n,
  input  logic [9:0]  ai,
  input  logic [2:0]  sdi_op,
  input  logic [15:0] sdi_len,
  output logic        cmd_valid,
  output logic [2:0]  opcode,
  output logic [15:0] run_len
);

  logic wr;
  logic wr_q;

  assign wr        = cardsel & ~wr_n & (ai == CMD_ADDR);
  assign cmd_valid = wr & ~wr_q;
  assign opcode    = sdi_op;
  assign run_len   = sdi_len;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= wr;
    end
  end

endmodule

// File: rtl/dlx_step_controller.sv
// Host-driven step/run/stop/init controller for the DLX core.
// Drives monitor strobes and the 32-bit step counter, all registered.
module dlx_step_controller
  import dlx_ctrl_pkg::*;
#(
  parameter logic [9:0] CMD_ADDR    = CMD_ADDR_DEF,
  parameter int         INIT_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CARDSEL,
  input  logic        WR_N,
  input  logic [9:0]  AI,
  input  logic [31:0] SDI,
  input  logic        halt,
  output logic        step_en,
  output logic        in_init,
  output logic        stop_n,
  output logic [31:0] step_counter,
  output logic        busy
);

  localparam int CW = $clog2(INIT_CYCLES + 1);

  state_e      state;
  logic [15:0] remaining;
  logic [CW-1:0] init_cnt;

  logic        cmd_valid;
  logic [2:0]  opcode;
  logic [15:0] run_len;
  logic        init_cmd;
  logic        step_cmd;
  logic        run_cmd;
  logic        stop_cmd;
  logic        unused_sdi;

  assign unused_sdi = ^SDI[15:3];

  step_cmd_decode #(
    .CMD_ADDR(CMD_ADDR)
  ) u_dec (
    .clk      (clk),
    .reset    (reset),
    .cardsel  (CARDSEL),
    .wr_n     (WR_N),
    .ai       (AI),
    .sdi_op   (SDI[2:0]),
    .sdi_len  (SDI[31:16]),
    .cmd_valid(cmd_valid),
    .opcode   (opcode),
    .run_len  (run_len)
  );

  always_comb begin
    init_cmd = 1'b0;
    step_cmd = 1'b0;
    run_cmd  = 1'b0;
    stop_cmd = 1'b0;
    if (cmd_valid) begin
      unique case (1'b1)
        (opcode == OP_INIT): init_cmd = 1'b1;
        (opcode == OP_STEP): step_cmd = 1'b1;
        (opcode == OP_RUN):  run_cmd  = 1'b1;
        (opcode == OP_STOP): stop_cmd = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      step_en      <= 1'b0;
      in_init      <= 1'b0;
      stop_n       <= 1'b1;
      busy         <= 1'b0;
      step_counter <= '0;
      remaining    <= '0;
      init_cnt     <= '0;
    end else begin
      step_counter <= step_counter + {31'd0, step_en};
      // INIT overrides everything, including the clear of a step in flight
      if (init_cmd) begin
        state        <= S_INIT;
        in_init      <= 1'b1;
        step_en      <= 1'b0;
        stop_n       <= 1'b1;
        busy         <= 1'b1;
        init_cnt     <= CW'(INIT_CYCLES - 1);
        step_counter <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (step_cmd) begin
              state   <= S_STEP;
              step_en <= 1'b1;
              busy    <= 1'b1;
            end else if (run_cmd) begin
              state     <= S_RUN;
              step_en   <= 1'b1;
              busy      <= 1'b1;
              remaining <= run_len;
            end
          end
          S_INIT: begin
            if (init_cnt == '0) begin
              state   <= S_IDLE;
              in_init <= 1'b0;
              busy    <= 1'b0;
            end else begin
              init_cnt <= init_cnt - 1'b1;
            end
          end
          S_STEP: begin
            step_en <= 1'b0;
            busy    <= 1'b0;
            if (halt) begin
              state  <= S_HALTED;
              stop_n <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end
          S_RUN: begin
            if (halt) begin
              state   <= S_HALTED;
              stop_n  <= 1'b0;
              step_en <= 1'b0;
              busy    <= 1'b0;
            end else if (stop_cmd || remaining == 16'd1) begin
              state   <= S_IDLE;
              step_en <= 1'b0;
              busy    <= 1'b0;
            end else if (remaining != 16'd0) begin
              remaining <= remaining - 16'd1;
            end
          end
          S_HALTED: ;
          default: begin
            state   <= S_IDLE;
            step_en <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
